// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg: shared types and helpers for the sequential shift-and-add
// multiplier (mult_seq_ctrl and mult_shift_add_dp).
//   state_e    : controller FSM states IDLE / RUN / DONE
//   cnt_width(): bit width of the step counter for a given operand width
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter has to hold 0..width-1. A width of 2 still needs one bit,
  // so the result never drops below 1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// ---------------------------------------------------------------------------
// mult_shift_add_dp: datapath of the shift-and-add multiplier.
// It holds the multiplicand (a_q) and the accumulator {hi_q, lo_q}.
// hi_q is WIDTH+1 bits so that the add carry has somewhere to land.
// lo_q starts as the multiplier and fills with product bits as it shifts.
//
// Optional feature (macro EARLY_TERM_EN): the extra_shift input adds further
// right shifts on top of the normal single-bit shift in the same step.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture op_a, load op_b into lo, clear hi
//   step          one add-then-shift step
//   op_a, op_b    operands (WIDTH bits each)
//   extra_shift   additional shift amount (EARLY_TERM_EN builds only)
//   acc_o         {hi[WIDTH-1:0], lo}; this is the product once all steps are done
// ---------------------------------------------------------------------------
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef EARLY_TERM_EN
  input  logic [CW-1:0]      extra_shift,
`endif
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
`ifdef EARLY_TERM_EN
  logic [CW:0]      shamt;
`endif

  always_comb begin
    a_d  = a_q;
    hi_d = hi_q;
    lo_d = lo_q;
    // hi_q is always below 2**WIDTH at the start of a step, because the
    // previous shift cleared the carry bit. So this sum cannot overflow WIDTH+1 bits.
    sum  = lo_q[0] ? (hi_q + {1'b0, a_q}) : hi_q;
`ifdef EARLY_TERM_EN
    shamt   = {1'b0, extra_shift} + {{CW{1'b0}}, 1'b1};
    shifted = {sum, lo_q} >> shamt;
`else
    shifted = {sum, lo_q} >> 1;
`endif
    if (load) begin
      a_d  = op_a;
      hi_d = '0;
      lo_d = op_b;
    end else if (step) begin
      hi_d = shifted[2*WIDTH:WIDTH];
      lo_d = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      a_q  <= a_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign acc_o = {hi_q[WIDTH-1:0], lo_q};

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl: sequencing controller for the unsigned shift-and-add
// multiplier. It accepts one request, runs one add-shift step per clock,
// then holds the 2*WIDTH-bit product until the consumer takes it.
//
// Handshake semantics (both sides):
//   - A transfer happens on a rising edge where valid && ready.
//   - Request side: in_ready is high only in IDLE. op_a/op_b are sampled on
//     the accepting edge. in_valid is ignored in RUN and DONE.
//   - Response side: out_valid rises WIDTH clocks after the accepting edge.
//     out_valid and product stay constant until out_valid && out_ready.
//     The next request can be accepted on the edge after that handshake.
//
// Optional feature (macro EARLY_TERM_EN): the controller can finish early
// once no set multiplier bits remain. The remaining shifts are then done
// in one cycle. In that build the latency is max(1, msb_index(op_b)+1).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    request handshake
//   op_a, op_b            multiplicand, multiplier (unsigned, WIDTH bits)
//   out_valid, out_ready  response handshake
//   product               op_a*op_b (2*WIDTH bits)
//   busy                  high while in RUN or DONE
// ---------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          dp_load;
  logic          dp_step;
  logic          finish;
  logic [2*WIDTH-1:0] acc;

`ifdef EARLY_TERM_EN
  logic [CW-1:0]    extra_shift;
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero;

  // After this step, the multiplier bits still to be consumed sit in
  // (acc_lo >> 1)[WIDTH-2-cnt:0]. The mask keeps exactly those
  // WIDTH-1-cnt positions.
  always_comb begin
    rem_mask = {WIDTH{1'b1}} >> ({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1});
    rem_zero = (((acc[WIDTH-1:0] >> 1) & rem_mask) == '0);
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    finish      = 1'b0;
`ifdef EARLY_TERM_EN
    extra_shift = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dp_step = 1'b1;
        finish  = (cnt_q == LAST_CNT);
`ifdef EARLY_TERM_EN
        if (rem_zero) begin
          // Only zero multiplier bits remain. Fold all the remaining
          // pure shifts into this step.
          finish      = 1'b1;
          extra_shift = LAST_CNT - cnt_q;
        end
`endif
        if (finish) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  mult_shift_add_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (dp_load),
    .step        (dp_step),
    .op_a        (op_a),
    .op_b        (op_b),
`ifdef EARLY_TERM_EN
    .extra_shift (extra_shift),
`endif
    .acc_o       (acc)
  );

  // in_ready is decoded from state, so it reads 1 while in reset.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // The accumulator is frozen in DONE, so product is steady while out_valid=1.
  assign product   = acc;

endmodule
